mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arb_starve_cnt.sv | 38 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port data-memory arbiter: read-return FSM
// encoding, port indices, bus widths and the default starvation limit.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam int MAX_WAIT_DEFAULT = 4;

    localparam int PORT_CPU    = 0;
    localparam int PORT_LOADER = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD0  = 2'd1;
    localparam logic [1:0] ST_RD1  = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Read-return state that belongs to a given port index.
    function automatic logic [1:0] rd_state(input int port);
        return (port == PORT_CPU) ? ST_RD0 : ST_RD1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-controller-side signals of the arbiter.
// slave = arbiter view, master = requesters plus memory controller view.
interface mem_arbiter_if;

    logic       p0_req;
    logic       p0_we;
    logic [7:0] p0_addr;
    logic [7:0] p0_wdata;
    logic       p0_gnt;
    logic       p0_rvalid;
    logic [7:0] p0_rdata;

    logic       p1_req;
    logic       p1_we;
    logic [7:0] p1_addr;
    logic [7:0] p1_wdata;
    logic       p1_gnt;
    logic       p1_rvalid;
    logic [7:0] p1_rdata;

    logic [7:0] m_writeaddr;
    logic [7:0] m_readaddr;
    logic [7:0] m_writedata;
    logic       m_write_en;
    logic [7:0] m_readdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  m_readdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output m_writeaddr, m_readaddr, m_writedata, m_write_en
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output m_readdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  m_writeaddr, m_readaddr, m_writedata, m_write_en
    );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles port 1 has been kept waiting; force_p1_o flags
// that the limit is reached and port 1 must win the next contended cycle.
module mem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic p1_req_i,
    input  logic p1_gnt_i,
    output logic force_p1_o
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!p1_req_i || p1_gnt_i) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Taken from the register only, so the grant path has no combinational loop.
    assign force_p1_o = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: p0 (CPU) priority with starvation relief for
// p1, one-cycle read return. Define MEM_ARB_STATS_EN to add conflict_count.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]    conflict_count
`endif
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata [2];
    mem_req_t    port_req [2];
    mem_req_t    sel;
    logic        force_p1;
    logic        p1_win;
    logic [1:0]  state_q;
    logic [1:0]  state_d;

    assign req[PORT_CPU]         = bus.p0_req;
    assign req[PORT_LOADER]      = bus.p1_req;
    assign port_req[PORT_CPU]    = {bus.p0_we, bus.p0_addr, bus.p0_wdata};
    assign port_req[PORT_LOADER] = {bus.p1_we, bus.p1_addr, bus.p1_wdata};

    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk        (clk),
        .reset      (reset),
        .p1_req_i   (req[PORT_LOADER]),
        .p1_gnt_i   (gnt[PORT_LOADER]),
        .force_p1_o (force_p1)
    );

    // Grants are masked while reset is held so nothing reaches the controller.
    always_comb begin
        p1_win = req[PORT_LOADER] && (!req[PORT_CPU] || force_p1);
        gnt    = 2'b00;
        if (!reset) begin
            gnt[PORT_LOADER] = p1_win;
            gnt[PORT_CPU]    = req[PORT_CPU] && !p1_win;
        end
    end

    always_comb begin
        sel = '0;
        if (gnt[PORT_CPU]) begin
            sel = port_req[PORT_CPU];
        end else if (gnt[PORT_LOADER]) begin
            sel = port_req[PORT_LOADER];
        end
    end

    assign bus.m_writeaddr = sel.addr;
    assign bus.m_readaddr  = sel.addr;
    assign bus.m_writedata = sel.wdata;
    assign bus.m_write_en  = sel.we;

    always_comb begin
        state_d = ST_IDLE;
        if (gnt[PORT_CPU] && !port_req[PORT_CPU].we) begin
            state_d = ST_RD0;
        end else if (gnt[PORT_LOADER] && !port_req[PORT_LOADER].we) begin
            state_d = ST_RD1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        assign rvalid[gi] = (state_q == rd_state(gi));
        assign rdata[gi]  = rvalid[gi] ? bus.m_readdata : 8'h00;
    end

    assign bus.p0_gnt    = gnt[PORT_CPU];
    assign bus.p1_gnt    = gnt[PORT_LOADER];
    assign bus.p0_rvalid = rvalid[PORT_CPU];
    assign bus.p1_rvalid = rvalid[PORT_LOADER];
    assign bus.p0_rdata  = rdata[PORT_CPU];
    assign bus.p1_rdata  = rdata[PORT_LOADER];

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q;
    logic [15:0] conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if ((&req) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the saturation test of
// conflict_count runs only when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    mem_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // Memory controller model: background data is addr ^ A5, plus one
    // remembered write; read data appears one cycle after the address.
    logic       wr_vld;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld         <= 1'b0;
            wr_addr        <= 8'h00;
            wr_data        <= 8'h00;
            bus.m_readdata <= 8'h00;
        end else begin
            if (bus.m_write_en) begin
                wr_vld  <= 1'b1;
                wr_addr <= bus.m_writeaddr;
                wr_data <= bus.m_writedata;
            end
            bus.m_readdata <= (wr_vld && wr_addr == bus.m_readaddr) ? wr_data
                                                                     : (bus.m_readaddr ^ 8'hA5);
        end
    end

    int checks   = 0;
    int failures = 0;

    // Bit i set: p1 must win contended cycle i (MAX_WAIT = 4).
    logic [9:0] p1_pat = 10'b10_0001_0000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        bus.p0_req   = r0;
        bus.p0_we    = w0;
        bus.p0_addr  = a0;
        bus.p0_wdata = d0;
        bus.p1_req   = r1;
        bus.p1_we    = w1;
        bus.p1_addr  = a1;
        bus.p1_wdata = d1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h44, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        check("rst_p0_gnt",  16'(bus.p0_gnt),      16'h0);
        check("rst_p1_gnt",  16'(bus.p1_gnt),      16'h0);
        check("rst_wen",     16'(bus.m_write_en),  16'h0);
        check("rst_waddr",   16'(bus.m_writeaddr), 16'h0);
        check("rst_raddr",   16'(bus.m_readaddr),  16'h0);
        check("rst_wdata",   16'(bus.m_writedata), 16'h0);
        check("rst_p0_rv",   16'(bus.p0_rvalid),   16'h0);
        check("rst_p1_rv",   16'(bus.p1_rvalid),   16'h0);
        check("rst_p0_rd",   16'(bus.p0_rdata),    16'h0);
        check("rst_p1_rd",   16'(bus.p1_rdata),    16'h0);
`ifdef MEM_ARB_STATS_EN
        check("rst_conflict", conflict_count, 16'h0);
`endif

        // p0 read of 0x20 alone, granted in the first cycle out of reset
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd20_p0_gnt", 16'(bus.p0_gnt),      16'h1);
        check("rd20_p1_gnt", 16'(bus.p1_gnt),      16'h0);
        check("rd20_raddr",  16'(bus.m_readaddr),  16'h20);
        check("rd20_waddr",  16'(bus.m_writeaddr), 16'h20);
        check("rd20_wen",    16'(bus.m_write_en),  16'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd20_p0_rv",  16'(bus.p0_rvalid),   16'h1);
        check("rd20_p0_rd",  16'(bus.p0_rdata),    16'h85);
        check("rd20_p1_rv",  16'(bus.p1_rvalid),   16'h0);
        check("idle_gnt",    16'(bus.p0_gnt),      16'h0);
        check("idle_raddr",  16'(bus.m_readaddr),  16'h0);

        // continuous contention: p0 x4, p1 x1, repeating; reads return in order
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) begin
                drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
            end else begin
                drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            #1;
            if (i < 10) begin
                check($sformatf("cont%0d_p1_gnt", i), 16'(bus.p1_gnt), 16'(p1_pat[i]));
                check($sformatf("cont%0d_p0_gnt", i), 16'(bus.p0_gnt), 16'(!p1_pat[i]));
                check($sformatf("cont%0d_raddr", i), 16'(bus.m_readaddr),
                      p1_pat[i] ? 16'h02 : 16'h01);
            end
            if (i > 0) begin
                check($sformatf("cont%0d_p1_rv", i), 16'(bus.p1_rvalid), 16'(p1_pat[i-1]));
                check($sformatf("cont%0d_p0_rv", i), 16'(bus.p0_rvalid), 16'(!p1_pat[i-1]));
                check($sformatf("cont%0d_p1_rd", i), 16'(bus.p1_rdata),
                      p1_pat[i-1] ? 16'hA7 : 16'h00);
                check($sformatf("cont%0d_p0_rd", i), 16'(bus.p0_rdata),
                      p1_pat[i-1] ? 16'h00 : 16'hA4);
            end
        end
`ifdef MEM_ARB_STATS_EN
        check("conflict_10", conflict_count, 16'd10);
`endif

        // p0 writes 5A to 0x30, p1 reads 0x30 the next cycle
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h30, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("wr30_p0_gnt", 16'(bus.p0_gnt),      16'h1);
        check("wr30_wen",    16'(bus.m_write_en),  16'h1);
        check("wr30_waddr",  16'(bus.m_writeaddr), 16'h30);
        check("wr30_wdata",  16'(bus.m_writedata), 16'h5A);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h33);
        #1;
        check("rd30_p1_gnt", 16'(bus.p1_gnt),      16'h1);
        check("rd30_wen",    16'(bus.m_write_en),  16'h0);
        check("rd30_raddr",  16'(bus.m_readaddr),  16'h30);
        check("rd30_wdata",  16'(bus.m_writedata), 16'h33);
        check("wr30_no_rv",  16'(bus.p0_rvalid),   16'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd30_p1_rv",  16'(bus.p1_rvalid),   16'h1);
        check("rd30_p1_rd",  16'(bus.p1_rdata),    16'h5A);
        check("idle2_wen",   16'(bus.m_write_en),  16'h0);
        check("idle2_waddr", 16'(bus.m_writeaddr), 16'h0);
        check("idle2_wdata", 16'(bus.m_writedata), 16'h0);

        // reset asserted right after a read is issued discards its return
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("midrst_p0_rv", 16'(bus.p0_rvalid), 16'h0);
        @(negedge clk);
        #1;
        check("inrst_p0_rv",  16'(bus.p0_rvalid), 16'h0);
        check("inrst_p1_rv",  16'(bus.p1_rvalid), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("postrst_p0_rv", 16'(bus.p0_rvalid), 16'h0);
        check("postrst_p1_rv", 16'(bus.p1_rvalid), 16'h0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
        #1;
        check("postrst_p1_gnt", 16'(bus.p1_gnt),     16'h1);
        check("postrst_p0_gnt", 16'(bus.p0_gnt),     16'h0);
        check("postrst_raddr",  16'(bus.m_readaddr), 16'h40);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd40_p1_rv", 16'(bus.p1_rvalid), 16'h1);
        check("rd40_p1_rd", 16'(bus.p1_rdata),  16'hE5);
        check("rd40_p0_rv", 16'(bus.p0_rvalid), 16'h0);

`ifdef MEM_ARB_STATS_EN
        check("conflict_after_rst", conflict_count, 16'h0);
        repeat (65540) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        end
        @(negedge clk);
        #1;
        check("conflict_sat", conflict_count, 16'hFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("conflict_hold", conflict_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
